// File: rtl/wb_uart_tx.sv
// Wishbone pipelined slave 8N1 UART transmitter with a small TX FIFO and programmable baud divisor.
// Define WB_UART_TX_PARITY_EN to add a CTRL-selectable even/odd parity bit between data and stop.
module wb_uart_tx #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [15:0] wb_adr,
  input  logic [15:0] wb_wdata,
  output logic        wb_ack,
  output logic        wb_stall,
  output logic [15:0] wb_rdata,
  output logic        txd
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = AW + 1;
`ifdef WB_UART_TX_PARITY_EN
  localparam int unsigned CW = 3;
`else
  localparam int unsigned CW = 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef WB_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state, state_nx;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic [15:0]     div;
  logic [CW-1:0]   ctrl;
  logic [15:0]     cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            full, empty, accept, push, pop, tick, busy;
  logic [15:0]     rd_val;
  logic            unused_adr;
`ifdef WB_UART_TX_PARITY_EN
  logic            par_en, par_bit;
`endif

  assign unused_adr = ^wb_adr[15:2];

  // Full uses the pre-pop level, so a DATA write to a full FIFO stalls even while a pop is underway.
  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign wb_stall = wb_cyc & wb_stb & wb_we & (wb_adr[1:0] == 2'd0) & full;
  assign accept   = wb_cyc & wb_stb & ~wb_stall;
  assign push     = accept & wb_we & (wb_adr[1:0] == 2'd0);
  assign pop      = (state == S_IDLE) & ctrl[0] & ~empty;
  assign tick     = (cnt == '0);

  always_comb begin
    rd_val = '0;
    case (wb_adr[1:0])
      2'd1:    rd_val = {7'b0, 5'(level), 1'b0, empty, full, busy};
      2'd2:    rd_val = div;
      2'd3:    rd_val = 16'(ctrl);
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
      div      <= DIV_RESET;
      ctrl     <= '0;
    end else begin
      wb_ack   <= accept;
      wb_rdata <= (accept & ~wb_we) ? rd_val : '0;
      if (accept & wb_we) begin
        if (wb_adr[1:0] == 2'd2) div  <= wb_wdata;
        if (wb_adr[1:0] == 2'd3) ctrl <= wb_wdata[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wb_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (pop) state_nx = S_START;
      S_START: if (tick) state_nx = S_DATA;
      S_DATA:
        if (tick && bit_idx == 3'd7) begin
`ifdef WB_UART_TX_PARITY_EN
          state_nx = par_en ? S_PARITY : S_STOP;
`else
          state_nx = S_STOP;
`endif
        end
`ifdef WB_UART_TX_PARITY_EN
      S_PARITY: if (tick) state_nx = S_STOP;
`endif
      S_STOP:  if (tick) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    txd  = 1'b1;
    busy = (state != S_IDLE);
    case (state)
      S_START:  txd = 1'b0;
      S_DATA:   txd = shreg[0];
`ifdef WB_UART_TX_PARITY_EN
      S_PARITY: txd = par_bit;
`endif
      default:  txd = 1'b1;
    endcase
  end

  // Counter reloads from the live DIV at each bit boundary, so DIV writes take effect on the next bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef WB_UART_TX_PARITY_EN
      par_en  <= 1'b0;
      par_bit <= 1'b0;
`endif
    end else if (pop) begin
      cnt     <= div;
      bit_idx <= '0;
      shreg   <= mem[rd_ptr];
`ifdef WB_UART_TX_PARITY_EN
      par_en  <= ctrl[1];
      par_bit <= (^mem[rd_ptr]) ^ ctrl[2];
`endif
    end else if (state != S_IDLE) begin
      if (tick) begin
        cnt <= div;
        if (state == S_DATA) begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        cnt <= cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed self-checking bench for wb_uart_tx: reset, framing, back-pressure, pipelining, DIV change.
module tb_wb_uart_tx;

  logic        clk, rst_n;
  logic        cyc, stb, we;
  logic [15:0] adr, wdata;
  logic        ack, stall, txd;
  logic [15:0] rdata;
  int          n_checks = 0;
  int          n_bad    = 0;

  wb_uart_tx #(.DEPTH(4), .DIV_RESET(16'd433)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr), .wb_wdata(wdata),
    .wb_ack(ack), .wb_stall(stall), .wb_rdata(rdata), .txd(txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge where the ack is seen.
  task automatic bus(input logic w, input logic [1:0] a, input logic [15:0] d, output logic [15:0] r);
    int n = 0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = {14'b0, a}; wdata = d;
    #1;
    while (stall && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n == 50) check_eq("stall_timeout", {15'b0, stall}, 16'h0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check_eq("ack", {15'b0, ack}, 16'h1);
    r = rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    logic [15:0] r;
    bus(1'b1, a, d, r);
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] r);
    bus(1'b0, a, 16'h0, r);
  endtask

  task automatic wait_idle(input string tag);
    logic [15:0] r;
    int n = 0;
    do begin
      rd(2'd1, r); n++;
    end while (r !== 16'h0004 && n < 400);
    check_eq(tag, r, 16'h0004);
  endtask

  task automatic check_frame(input string tag, input logic [10:0] bits, input int nb,
                             input int hold, input logic last);
    int n = 0;
    @(negedge clk);
    while (txd !== 1'b0 && n < 100) begin
      @(negedge clk); n++;
    end
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < hold; k++) begin
        if (b != 0 || k != 0) @(negedge clk);
        check_eq(tag, {15'b0, txd}, {15'b0, bits[b]});
      end
    end
    @(negedge clk);
    check_eq({tag, "_idle"}, {15'b0, txd}, 16'h1);
    @(negedge clk);
    check_eq({tag, "_next"}, {15'b0, txd}, {15'b0, last});
  endtask

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdata = '0;
    #1;
    check_eq("rst_txd",   {15'b0, txd},   16'h1);
    check_eq("rst_ack",   {15'b0, ack},   16'h0);
    check_eq("rst_stall", {15'b0, stall}, 16'h0);
    check_eq("rst_rdata", rdata,          16'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(2'd1, r); check_eq("rst_status", r, 16'h0004);
    rd(2'd2, r); check_eq("rst_div",    r, 16'd433);
    rd(2'd3, r); check_eq("rst_ctrl",   r, 16'h0000);

    // single byte A5 at DIV=3
    wr(2'd2, 16'd3);
    wr(2'd3, 16'h1);
    wr(2'd0, 16'h00A5);
    check_frame("a5_frame", {1'b0, 1'b1, 8'hA5, 1'b0}, 10, 4, 1'b1);
    wr(2'd0, 16'h00A5);
    rd(2'd1, r); check_eq("a5_stat_queued", r, 16'h0010);
    rd(2'd1, r); check_eq("a5_stat_busy",   r, 16'h0005);
    wait_idle("a5_stat_done");

    // back-pressure with DEPTH=4
    wr(2'd3, 16'h0);
    wr(2'd2, 16'h0);
    for (int i = 0; i < 4; i++) begin
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0; wdata = 16'(8'h10 + i);
      #1 check_eq("bp_nostall", {15'b0, stall}, 16'h0);
      @(negedge clk);
      check_eq("bp_ack", {15'b0, ack}, 16'h1);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rd(2'd1, r); check_eq("bp_status_full", r, 16'h0042);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0; wdata = 16'h0014;
    #1 check_eq("bp_stall", {15'b0, stall}, 16'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_eq("bp_stall_hold", {15'b0, stall}, 16'h1);
      check_eq("bp_no_ack",     {15'b0, ack},   16'h0);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    wr(2'd3, 16'h1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0; wdata = 16'h0014;
    #1 check_eq("bp_stall_prepop", {15'b0, stall}, 16'h1);
    @(negedge clk); #1;
    check_eq("bp_stall_release", {15'b0, stall}, 16'h0);
    check_eq("bp_ack_pending",   {15'b0, ack},   16'h0);
    @(negedge clk);
    check_eq("bp_fifth_ack", {15'b0, ack}, 16'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wait_idle("bp_drain");
    wr(2'd3, 16'h0);

    // pipelined: write DIV, read DIV, read STATUS on consecutive cycles
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h2; wdata = 16'h0007;
    @(negedge clk);
    check_eq("pipe_ack0", {15'b0, ack}, 16'h1);
    check_eq("pipe_dat0", rdata, 16'h0000);
    we = 1'b0; adr = 16'h2;
    @(negedge clk);
    check_eq("pipe_ack1", {15'b0, ack}, 16'h1);
    check_eq("pipe_dat1", rdata, 16'h0007);
    adr = 16'h1;
    @(negedge clk);
    check_eq("pipe_ack2", {15'b0, ack}, 16'h1);
    check_eq("pipe_dat2", rdata, 16'h0004);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check_eq("pipe_ack_off", {15'b0, ack}, 16'h0);
    check_eq("pipe_dat_off", rdata, 16'h0000);

    // DIV 3 -> 1 written during bit 2 of FF; a queued 00 exposes the frame end
    wr(2'd2, 16'd3);
    wr(2'd0, 16'h00FF);
    wr(2'd0, 16'h0000);
    wr(2'd3, 16'h1);
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (txd !== 1'b0 && n < 50);
      check_eq("dc_t0", {15'b0, txd}, 16'h0);
      for (int t = 1; t <= 30; t++) begin
        logic e;
        @(negedge clk);
        if (t == 14) begin
          check_eq("dc_div_ack", {15'b0, ack}, 16'h1);
          cyc = 1'b0; stb = 1'b0; we = 1'b0;
        end
        e = (t < 4 || t >= 29) ? 1'b0 : 1'b1;
        check_eq("dc_txd", {15'b0, txd}, {15'b0, e});
        if (t == 13) begin
          cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h2; wdata = 16'h0001;
        end
      end
    end
    wait_idle("dc_drain");
    wr(2'd3, 16'h0);

`ifdef WB_UART_TX_PARITY_EN
    wr(2'd2, 16'd1);
    wr(2'd0, 16'h0007);
    wr(2'd0, 16'h0007);
    wr(2'd3, 16'h3);
    check_frame("par_even", {1'b1, 1'b1, 8'h07, 1'b0}, 11, 2, 1'b0);
    wait_idle("par_even_drain");
    wr(2'd3, 16'h0);
    wr(2'd0, 16'h0007);
    wr(2'd0, 16'h0007);
    wr(2'd3, 16'h7);
    check_frame("par_odd", {1'b1, 1'b0, 8'h07, 1'b0}, 11, 2, 1'b0);
    wait_idle("par_odd_drain");
    rd(2'd3, r); check_eq("ctrl_readback", r, 16'h0007);
`else
    wr(2'd3, 16'h7);
    rd(2'd3, r); check_eq("ctrl_readback", r, 16'h0001);
`endif
    wr(2'd3, 16'h0);

    // reset mid-frame with queued bytes
    wr(2'd2, 16'd3);
    wr(2'd3, 16'h1);
    wr(2'd0, 16'h0000);
    wr(2'd0, 16'h0000);
    wr(2'd0, 16'h0000);
    repeat (8) @(negedge clk);
    check_eq("mid_txd_low", {15'b0, txd}, 16'h0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_txd", {15'b0, txd}, 16'h1);
    check_eq("mid_rst_ack", {15'b0, ack}, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(2'd1, r); check_eq("mid_rst_status", r, 16'h0004);
    rd(2'd2, r); check_eq("mid_rst_div",    r, 16'd433);
    rd(2'd3, r); check_eq("mid_rst_ctrl",   r, 16'h0000);
    repeat (5) @(negedge clk);
    check_eq("mid_rst_txd_hold", {15'b0, txd}, 16'h1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_uart_tx.md
Name: wb_uart_tx

Overview:
- Pipelined Wishbone slave: 8N1 UART transmitter for the J1 data-bus I/O windows (e.g. 4000H–4FFFH).
- Response-side end of the bus: accepts strobes from the interconnect and returns ack/stall/dat_o.
- Written bytes queue in a small FIFO, then shift out LSB-first on txd at a programmable baud divisor.
- Decodes adr[1:0] only; the interconnect already gates cyc/stb by window.

Parameters:
- DEPTH, 4, TX FIFO depth in bytes; power of two, 2..16.
- DIV_RESET, 16'd433, divisor reset value; bit period = DIV+1 clocks.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wb  if_wb.slave  -  Wishbone pipelined slave; members used: cyc, stb, we, adr[15:0], dat_i[15:0] (in); ack, stall, dat_o[15:0] (out).
- txd  output  1  serial output, idle high.

Behaviour:
- Reset (async, rst_n=0): wb.ack=0, wb.stall=0, wb.dat_o=0, txd=1, FIFO empty, DIV=DIV_RESET, CTRL=0, FSM=IDLE.
- Register map (adr[1:0]):
  - 0 DATA: write pushes dat_i[7:0]; read returns 0.
  - 1 STATUS (RO): bit0 busy (FSM!=IDLE), bit1 full, bit2 empty, bits[8:4] FIFO level; other bits 0.
  - 2 DIV (RW): 16 bits.
  - 3 CTRL (RW): bit0 enable; other bits read 0.
- Handshake:
  - Request = cyc & stb. Accepted when request & !stall.
  - stall is combinational = cyc & stb & we & (adr[1:0]==0) & full; it is 0 in every other case.
  - ack is registered: high exactly one cycle after each accepted request, zero wait states, back-to-back accepts allowed.
  - Read data is registered with ack and is valid only while ack=1. dat_o=0 otherwise.
  - If cyc=0 in the cycle after acceptance, ack is still driven and the register side effect stands.
- FIFO:
  - Push on accepted DATA write; pop when FSM leaves IDLE.
  - Full test uses the pre-pop level, so a DATA write to a full FIFO stalls even in a pop cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO keep the level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: txd=1. If enable & !empty, pop the byte into the shift register, load the baud counter with DIV, go to START.
  - START: txd=0 for DIV+1 clocks.
  - DATA: 8 bits LSB first, each held DIV+1 clocks; a 3-bit counter wraps 7->0, then go to STOP.
  - STOP: txd=1 for DIV+1 clocks, then IDLE. The next byte may start the following cycle (no extra idle).
- Baud counter: down-counter reloaded from DIV at every bit boundary. A DIV write mid-frame applies from the next bit. DIV=0 gives 1 clock per bit.
- Clearing enable mid-frame completes the current frame; no new pop follows.
- Reset mid-frame aborts immediately: txd=1, FIFO contents discarded.

Optional Feature:
- Macro WB_UART_TX_PARITY_EN.
- Defined:
  - CTRL bit1 = parity enable, bit2 = odd (0 = even); both readable.
  - With bit1=1, FSM inserts a PARITY state between DATA and STOP.
  - PARITY drives the XOR of the 8 data bits (inverted if odd) for DIV+1 clocks.
- Undefined: CTRL bits 1–2 read 0 and writes are ignored; no PARITY state is synthesized.

Test Plan:
- Reset: hold rst_n=0 mid-frame -> txd=1, ack=0, STATUS read after release = 16'h0004; DIV reads 433.
- Single byte: DIV=3, CTRL=1, write DATA=8'hA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each held exactly 4 clocks; STATUS busy=1 during frame, 0 after.
- Back-pressure: CTRL=0, DEPTH=4, write 5 bytes back-to-back -> first 4 acked on consecutive cycles, level=4, full=1. Fifth holds stall=1 until CTRL=1 pops a byte, then is acked one cycle later.
- Pipelined mixed traffic: stb on 3 consecutive cycles (write DIV=7, read DIV, read STATUS) -> 3 acks on consecutive cycles; the second ack returns 16'h0007.
- Mid-frame DIV change: DIV=3, start 8'hFF, write DIV=1 during bit 2 -> bit 2 keeps 4 clocks, bits 3..7 and stop take 2 clocks each.
- Parity (macro defined): CTRL=3'b011, byte 8'h07 -> parity bit = 1 between bit 7 and stop; with CTRL=3'b111, parity bit = 0.
